arbitro_rr_mux: RTL
===================

Name: arbitro_rr_mux

Overview:
- Round-robin scheduler for the shared 2:1 data multiplexer. It arbitrates two valid-qualified requesters, drives the mux `selector`, and registers the muxed word toward one downstream consumer with a ready/valid handshake.
- A burst limit (MAX_BURST) caps consecutive transfers from one source while the other source is waiting.
- Sits directly in front of the 2-bit mux datapath and replaces a free-running `selector` stimulus with a sequenced, fair one.

Parameters:
- BUS_WIDTH, 2: width of data_in0/data_in1/data_out.
- MAX_BURST, 4: maximum consecutive accepted words from one source while the other is requesting; legal range 1..15.

Ports:
- clk  input  1  single system clock, all state updates on posedge.
- reset_L  input  1  asynchronous, active-low reset.
- valid_in0  input  1  source 0 has a word on data_in0.
- data_in0  input  BUS_WIDTH  source 0 data.
- valid_in1  input  1  source 1 has a word on data_in1.
- data_in1  input  BUS_WIDTH  source 1 data.
- pop0  output  1  combinational; source 0 word accepted this cycle.
- pop1  output  1  combinational; source 1 word accepted this cycle.
- ready_out  input  1  downstream accepts data_out this cycle.
- valid_out  output  1  registered; data_out holds a valid word.
- data_out  output  BUS_WIDTH  registered muxed word.
- selector  output  1  registered current grant (0 = source 0, 1 = source 1); drives the mux.

Behaviour:
- Reset (reset_L=0, asynchronous, takes effect immediately):
  - state=IDLE, selector=0, valid_out=0, data_out=0, burst_cnt=0, last=1, so source 0 wins the first tie.
  - Any word held in data_out is discarded.
  - pop0 and pop1 are forced to 0 while reset is asserted.
- States: IDLE, SERVE0, SERVE1. selector=0 in SERVE0, 1 in SERVE1, and holds its last value in IDLE.
- Output register free: slot_free = !valid_out | ready_out.
- Acceptance: pop_i = (state==SERVEi) & valid_ini & slot_free. At most one pop per cycle; pops never occur in IDLE.
- Datapath, at posedge:
  - If pop_i: data_out<=data_ini and valid_out<=1.
  - Else if valid_out & ready_out: valid_out<=0 and data_out holds.
  - Else both hold.
  - Latency is 1 cycle from pop to valid_out.
- burst_cnt increments on each pop of the served source. Stall cycles (slot_free=0) do not change it. It clears to 0 on every state change.
- Transitions, evaluated at posedge:
  - IDLE, both valid: go to SERVE(!last).
  - IDLE, only valid_in0: go to SERVE0.
  - IDLE, only valid_in1: go to SERVE1.
  - IDLE, neither valid: stay.
  - SERVEi, valid_ini=0: go to SERVE(other) if the other source is valid, else IDLE. Set last=i.
  - SERVEi, pop_i with burst_cnt==MAX_BURST-1 and the other source valid: go to SERVE(other), set last=i. No bubble; the new source may pop on the next cycle.
  - SERVEi, pop_i with burst_cnt==MAX_BURST-1 and the other source idle: stay in SERVEi, burst_cnt<=0.
  - Otherwise stay.
- A source dropping valid mid-burst costs exactly one bubble cycle before the other source is served.
- MAX_BURST=1: with both sources valid, grants alternate every transfer.
- burst_cnt width is 4 bits; it never exceeds MAX_BURST-1.
- Simultaneous pop and downstream drain in the same cycle: the new word replaces the drained word, valid_out stays 1 (full throughput).
- The inputs valid_in/data_in must be stable while valid_in is high and pop is low (source contract; checked by the bench, not by the block).

Test Plan:
- Reset with both valid_in=1: hold reset_L=0 for 2 cycles → pop0=pop1=0, valid_out=0, data_out=0, selector=0. Release → SERVE0 after 1 edge, then pop0=1.
- Single source, only valid_in0=1, data_in0=3, ready_out=1 → pop0=1 every cycle from the 2nd cycle after release; data_out=3 and valid_out=1 one cycle after each pop; selector stays 0; pop1 never asserted.
- Fairness, both valid continuously, data_in0=1, data_in1=2, MAX_BURST=4, ready_out=1 → pop pattern 0,0,0,0,1,1,1,1,0,… with no bubbles; selector toggles every 4 cycles; data_out follows with 1-cycle lag.
- Backpressure, valid_out=1 with ready_out=0 for 3 cycles mid-burst → no pops, data_out held, burst_cnt unchanged. After ready_out=1 the burst completes its remaining count before switching.
- Source drop, valid_in0 deasserted after 2 accepted words with valid_in1=1 → one cycle with neither pop, then SERVE1, selector=1, pop1=1.
- Reset mid-burst, reset_L pulled low between edges during SERVE1 → valid_out=0 and selector=0 immediately, without waiting for an edge. After release with both valid, source 0 is served first.

Source files
------------

// File: rtl/arbitro_rr_mux.sv
// arbitro_rr_mux: round-robin, burst-limited scheduler for two valid-qualified
// sources feeding a 2:1 mux, with a registered ready/valid output stage.
module arbitro_rr_mux #(
    parameter int BUS_WIDTH = 2,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 valid_in0,
    input  logic [BUS_WIDTH-1:0] data_in0,
    input  logic                 valid_in1,
    input  logic [BUS_WIDTH-1:0] data_in1,
    output logic                 pop0,
    output logic                 pop1,
    input  logic                 ready_out,
    output logic                 valid_out,
    output logic [BUS_WIDTH-1:0] data_out,
    output logic                 selector
);

    typedef enum logic [1:0] {IDLE = 2'd0, SERVE0 = 2'd1, SERVE1 = 2'd2} state_t;

    localparam logic [3:0] CNT_LAST = 4'(MAX_BURST - 1);

    state_t               state_q, state_d;
    logic                 last_q, last_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 sel_q, sel_d;
    logic                 valid_q, valid_d;
    logic [BUS_WIDTH-1:0] data_q, data_d;

    logic   slot_free, cur, v_cur, v_oth, pop_cur;
    state_t other;

    assign slot_free = !valid_q || ready_out;
    assign cur       = (state_q == SERVE1);
    assign v_cur     = cur ? valid_in1 : valid_in0;
    assign v_oth     = cur ? valid_in0 : valid_in1;
    assign other     = cur ? SERVE0 : SERVE1;
    assign pop_cur   = pop0 || pop1;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= 4'd0;
            sel_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE) begin
            if (valid_in0 && valid_in1) state_d = last_q ? SERVE0 : SERVE1;
            else if (valid_in0)         state_d = SERVE0;
            else if (valid_in1)         state_d = SERVE1;
        end else if (!v_cur) begin
            state_d = v_oth ? other : IDLE;
            last_d  = cur;
            cnt_d   = 4'd0;
        end else if (pop_cur) begin
            // Burst exhausted: hand over only if the other side is waiting.
            if (cnt_q == CNT_LAST) begin
                cnt_d = 4'd0;
                if (v_oth) begin
                    state_d = other;
                    last_d  = cur;
                end
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_comb begin
        pop0 = reset_L && (state_q == SERVE0) && valid_in0 && slot_free;
        pop1 = reset_L && (state_q == SERVE1) && valid_in1 && slot_free;
    end

    always_comb begin
        sel_d   = (state_d == SERVE1) ? 1'b1 : (state_d == SERVE0) ? 1'b0 : sel_q;
        valid_d = pop_cur ? 1'b1 : (valid_q && ready_out) ? 1'b0 : valid_q;
        data_d  = pop1 ? data_in1 : pop0 ? data_in0 : data_q;
    end

    assign valid_out = valid_q;
    assign data_out  = data_q;
    assign selector  = sel_q;

endmodule
